sti_deserializer: RTL and testbench

//  Serial-to-parallel receiver for the STI serial stream (valid + 1-bit data).

---
 rtl/sti_deserializer.sv | 148 ++++++++++++++
 tb/tb_sti_deserializer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sti_deserializer.sv
// sti_deserializer
//   Serial-to-parallel receiver for the STI stream. Rebuilds 8/16/24/32-bit
//   words (MSB- or LSB-first), extracts the 16-bit payload and writes each
//   completed word at an incrementing, wrapping address.
// Ports
//   clk, rst            clock (rising edge), async active-high reset
//   si_valid/si_data    serial bit strobe and bit
//   si_end              end of stream, honoured only while idle
//   cfg_length/msb/fill/low  word format, latched on the first bit of a word
//   po_valid            1-cycle pulse: po_data/po_payload/po_addr updated
//   po_data/po_payload  raw word (zero-extended) and recovered payload
//   po_addr             address of the delivered word
//   po_err              1-cycle pulse: word aborted because si_valid dropped
//   po_done             level, stream finished (cleared only by reset)
module sti_deserializer #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              si_valid,
    input  logic              si_data,
    input  logic              si_end,
    input  logic [1:0]        cfg_length,
    input  logic              cfg_msb,
    input  logic              cfg_fill,
    input  logic              cfg_low,
    output logic              po_valid,
    output logic [31:0]       po_data,
    output logic [15:0]       po_payload,
    output logic [ADDR_W-1:0] po_addr,
    output logic              po_err,
    output logic              po_done
);

    typedef enum logic [1:0] {IDLE, RECV, FINISH} state_t;

    state_t            state, state_n;
    logic [4:0]        cnt;
    logic [31:0]       sr, sr_n, word, mask;
    logic [15:0]       payload;
    logic [1:0]        len_q;
    logic              msb_q, fill_q, low_q;
    logic [ADDR_W-1:0] addr;
    logic              start, shift, word_done, abort;

    always_comb begin
        state_n   = state;
        start     = 1'b0;
        shift     = 1'b0;
        word_done = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (si_valid) begin
                    start   = 1'b1;
                    state_n = RECV;
                end else if (si_end) begin
                    state_n = FINISH;
                end
            end
            RECV: begin
                if (si_valid) begin
                    shift = 1'b1;
                    // Index of the last bit is 8*(len+1)-1 = {len,3'b111}.
                    if (cnt == {len_q, 3'b111}) begin
                        word_done = 1'b1;
                        // A following bit is picked up by IDLE on the very
                        // next cycle, so back-to-back words need no gap.
                        state_n   = IDLE;
                    end
                end else begin
                    abort   = 1'b1;
                    state_n = IDLE;
                end
            end
            FINISH:  state_n = FINISH;
            default: state_n = IDLE;
        endcase
    end

    // Next shift-register value; the first bit of a word clears the old one.
    always_comb begin
        sr_n = sr;
        if (start) begin
            sr_n = {31'd0, si_data};
        end else if (shift) begin
            if (msb_q) sr_n = {sr[30:0], si_data};
            else       sr_n[cnt] = si_data;
        end
    end

    always_comb begin
        case (len_q)
            2'd0:    mask = 32'h0000_00FF;
            2'd1:    mask = 32'h0000_FFFF;
            2'd2:    mask = 32'h00FF_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        word = sr_n & mask;
        case (len_q)
            2'd0:    payload = low_q ? {word[7:0], 8'h00} : {8'h00, word[7:0]};
            2'd1:    payload = word[15:0];
            2'd2:    payload = fill_q ? word[23:8]  : word[15:0];
            default: payload = fill_q ? word[31:16] : word[15:0];
        endcase
    end

    assign po_done = (state == FINISH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sr         <= '0;
            len_q      <= '0;
            msb_q      <= 1'b0;
            fill_q     <= 1'b0;
            low_q      <= 1'b0;
            addr       <= '0;
            po_valid   <= 1'b0;
            po_err     <= 1'b0;
            po_data    <= '0;
            po_payload <= '0;
            po_addr    <= '0;
        end else begin
            state    <= state_n;
            po_valid <= word_done;
            po_err   <= abort;
            if (start) begin
                len_q  <= cfg_length;
                msb_q  <= cfg_msb;
                fill_q <= cfg_fill;
                low_q  <= cfg_low;
            end
            if (start)                  cnt <= 5'd1;
            else if (word_done | abort) cnt <= 5'd0;
            else if (shift)             cnt <= cnt + 5'd1;
            if (start | shift) sr <= sr_n;
            if (word_done) begin
                po_data    <= word;
                po_payload <= payload;
                po_addr    <= addr;
                addr       <= addr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sti_deserializer.sv
// tb_sti_deserializer
//   Directed and randomized stimulus for sti_deserializer. Two instances share
//   all inputs: ADDR_W=8 (full check) and ADDR_W=2 (address wrap check).
//   Expected outputs come from the word values the bench chooses to send.
module tb_sti_deserializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        si_valid = 1'b0, si_data = 1'b0, si_end = 1'b0;
    logic [1:0]  cfg_length = 2'd0;
    logic        cfg_msb = 1'b0, cfg_fill = 1'b0, cfg_low = 1'b0;
    logic        po_valid, po_err, po_done;
    logic [31:0] po_data;
    logic [15:0] po_payload;
    logic [7:0]  po_addr;
    logic        po_valid2, po_err2, po_done2;
    logic [31:0] po_data2;
    logic [15:0] po_payload2;
    logic [1:0]  po_addr2;

    sti_deserializer #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .si_valid(si_valid), .si_data(si_data), .si_end(si_end),
        .cfg_length(cfg_length), .cfg_msb(cfg_msb), .cfg_fill(cfg_fill), .cfg_low(cfg_low),
        .po_valid(po_valid), .po_data(po_data), .po_payload(po_payload), .po_addr(po_addr),
        .po_err(po_err), .po_done(po_done));

    sti_deserializer #(.ADDR_W(2)) dut2 (
        .clk(clk), .rst(rst), .si_valid(si_valid), .si_data(si_data), .si_end(si_end),
        .cfg_length(cfg_length), .cfg_msb(cfg_msb), .cfg_fill(cfg_fill), .cfg_low(cfg_low),
        .po_valid(po_valid2), .po_data(po_data2), .po_payload(po_payload2), .po_addr(po_addr2),
        .po_err(po_err2), .po_done(po_done2));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected outputs for the next negedge sample.
    logic        exp_v = 1'b0, exp_err = 1'b0, exp_done = 1'b0;
    logic [31:0] exp_data = '0;
    logic [15:0] exp_pay = '0;
    logic [7:0]  exp_addr = '0;
    logic [7:0]  mdl_addr = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("valid",   32'(po_valid),   32'(exp_v));
        chk("err",     32'(po_err),     32'(exp_err));
        chk("done",    32'(po_done),    32'(exp_done));
        chk("data",    po_data,         exp_data);
        chk("payload", 32'(po_payload), 32'(exp_pay));
        chk("addr",    32'(po_addr),    32'(exp_addr));
        chk("valid2",  32'(po_valid2),  32'(exp_v));
        chk("err2",    32'(po_err2),    32'(exp_err));
        chk("addr2",   32'(po_addr2),   32'(exp_addr[1:0]));
    endtask

    function automatic logic [15:0] pay(input logic [1:0] len, input logic fill, low,
                                        input logic [31:0] w);
        case (len)
            2'd0:    return low ? {w[7:0], 8'h00} : {8'h00, w[7:0]};
            2'd1:    return w[15:0];
            2'd2:    return fill ? w[23:8] : w[15:0];
            default: return fill ? w[31:16] : w[15:0];
        endcase
    endfunction

    // One cycle: check what the previous cycle should have produced, then drive.
    task automatic step(input logic v, input logic d, input logic e);
        @(negedge clk);
        check_all();
        si_valid = v;
        si_data  = d;
        si_end   = e;
        exp_v    = 1'b0;
        exp_err  = 1'b0;
    endtask

    // Send nsend bits of a word; nsend < N aborts it by dropping si_valid.
    task automatic send_word(input logic [1:0] len, input logic msb, input logic fill,
                             input logic low, input logic [31:0] val, input int nsend);
        int          n;
        logic [63:0] mask;
        logic [31:0] w;
        n    = 8 * (int'(len) + 1);
        mask = (64'd1 << n) - 64'd1;
        w    = val & mask[31:0];
        for (int i = 0; i < nsend; i++) begin
            step(1'b1, msb ? w[n-1-i] : w[i], 1'b0);
            if (i == 0) begin
                cfg_length = len; cfg_msb = msb; cfg_fill = fill; cfg_low = low;
            end else begin
                {cfg_length, cfg_msb, cfg_fill, cfg_low} = 5'($urandom);
            end
        end
        if (nsend == n) begin
            exp_v    = 1'b1;
            exp_data = w;
            exp_pay  = pay(len, fill, low, w);
            exp_addr = mdl_addr;
            mdl_addr = mdl_addr + 8'd1;
        end else begin
            step(1'b0, 1'b0, 1'b0);
            exp_err = 1'b1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state.
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // 8-bit MSB-first 0xA5.
        send_word(2'd0, 1'b1, 1'b0, 1'b0, 32'hA5, 8);
        step(1'b0, 1'b0, 1'b0);
        // 16-bit LSB-first, back-to-back.
        send_word(2'd1, 1'b0, 1'b0, 1'b0, 32'h1234, 16);
        send_word(2'd1, 1'b0, 1'b0, 1'b0, 32'h5678, 16);
        // 32-bit fill variants.
        send_word(2'd3, 1'b1, 1'b1, 1'b0, 32'hBEEF0000, 32);
        send_word(2'd3, 1'b1, 1'b0, 1'b0, 32'h0000BEEF, 32);
        // 8-bit high-byte payload, 24-bit fill.
        send_word(2'd0, 1'b0, 1'b0, 1'b1, 32'h3C, 8);
        send_word(2'd2, 1'b1, 1'b1, 1'b0, 32'hABCDEF, 24);
        // 24-bit abort after 12 bits, then a full word at the same address.
        send_word(2'd2, 1'b1, 1'b0, 1'b0, 32'h123456, 12);
        send_word(2'd2, 1'b1, 1'b0, 1'b0, 32'h654321, 24);
        step(1'b0, 1'b0, 1'b0);

        // Randomized traffic, including gaps and aborts.
        for (int k = 0; k < 60; k++) begin
            logic [1:0] len;
            int         n, ns;
            len = 2'($urandom);
            n   = 8 * (int'(len) + 1);
            ns  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, n - 1) : n;
            send_word(len, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, ns);
            for (int g = $urandom_range(0, 2); g > 0; g--) step(1'b0, 1'($urandom), 1'b0);
        end

        // Reset in the middle of a word after a delivered word.
        send_word(2'd1, 1'b1, 1'b0, 1'b0, 32'hC0DE, 16);
        step(1'b1, 1'b1, 1'b0);
        cfg_length = 2'd1; cfg_msb = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        exp_v = 1'b0; exp_err = 1'b0; exp_done = 1'b0;
        exp_data = '0; exp_pay = '0; exp_addr = '0; mdl_addr = '0;
        check_all();
        si_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Five words after reset: addresses restart at 0, dut2 wraps 0,1,2,3,0.
        for (int k = 0; k < 5; k++) send_word(2'd0, 1'b1, 1'b0, 1'b0, 32'(k * 17 + 1), 8);
        step(1'b0, 1'b0, 1'b0);

        // End of stream; later serial traffic is ignored.
        step(1'b0, 1'b0, 1'b1);
        exp_done = 1'b1;
        for (int k = 0; k < 12; k++) step(1'b1, 1'($urandom), 1'($urandom));
        step(1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
